ts_avg: RTL and testbench



---
 rtl/ts_avg.sv | 72 +++++++
 tb/tb_ts_avg.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ts_avg.sv
// rtl/ts_avg.sv - dual-channel sliding-window sensor averager
module ts_avg #(
   parameter int LOG2_DEPTH = 3,
   parameter int W          = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic         s_ch,
   input  logic [W-1:0] s_data,
   output logic [W-1:0] ts1,
   output logic [W-1:0] ts2,
   output logic         ts_valid,
   output logic         upd
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SW    = W + LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH + 1)'(DEPTH);

   // Per-channel window storage; index 0 feeds ts1, index 1 feeds ts2
   logic [W-1:0]          ring [2][DEPTH];
   logic [LOG2_DEPTH-1:0] ptr  [2];
   logic [LOG2_DEPTH:0]   fill [2];
   logic [SW-1:0]         sum  [2];

   logic [W-1:0]          old;
   logic [SW-1:0]         new_sum;
   logic [LOG2_DEPTH:0]   fill0_nxt;
   logic [LOG2_DEPTH:0]   fill1_nxt;

   // Evict the oldest sample of the selected channel and fold in the new one;
   // old is already inside sum, so the subtraction never underflows
   always_comb begin
      old       = ring[s_ch][ptr[s_ch]];
      new_sum   = sum[s_ch] - SW'(old) + SW'(s_data);
      fill0_nxt = fill[0];
      fill1_nxt = fill[1];
      if (s_valid && !s_ch && fill[0] != FULL) fill0_nxt = fill[0] + (LOG2_DEPTH + 1)'(1);
      if (s_valid &&  s_ch && fill[1] != FULL) fill1_nxt = fill[1] + (LOG2_DEPTH + 1)'(1);
   end

   // Window state, registered averages and status flags; reset wins over a sample
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < DEPTH; i++) ring[c][i] <= '0;
            ptr[c]  <= '0;
            fill[c] <= '0;
            sum[c]  <= '0;
         end
         ts1      <= '0;
         ts2      <= '0;
         ts_valid <= 1'b0;
         upd      <= 1'b0;
      end else begin
         upd      <= s_valid;
         fill[0]  <= fill0_nxt;
         fill[1]  <= fill1_nxt;
         ts_valid <= (fill0_nxt == FULL) && (fill1_nxt == FULL);
         if (s_valid) begin
            ring[s_ch][ptr[s_ch]] <= s_data;
            ptr[s_ch]             <= ptr[s_ch] + LOG2_DEPTH'(1);
            sum[s_ch]             <= new_sum;
            // Empty slots hold 0, so the average is always sum/DEPTH
            if (s_ch) ts2 <= new_sum[SW-1:LOG2_DEPTH];
            else      ts1 <= new_sum[SW-1:LOG2_DEPTH];
         end
      end
   end

endmodule

// File: tb/tb_ts_avg.sv
// tb/tb_ts_avg.sv - self-checking bench for ts_avg
module tb_ts_avg;

   localparam int LD    = 3;
   localparam int W     = 8;
   localparam int DEPTH = 1 << LD;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ch = 1'b0;
   logic [W-1:0] s_data = '0;
   logic [W-1:0] ts1;
   logic [W-1:0] ts2;
   logic         ts_valid;
   logic         upd;

   int total = 0;
   int bad   = 0;

   // Reference: each channel's window is a queue of the last DEPTH samples
   int q0[$];
   int q1[$];
   int cnt0, cnt1;
   int e1, e2, ev, eu;

   ts_avg #(.LOG2_DEPTH(LD), .W(W)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
      .ts1(ts1), .ts2(ts2), .ts_valid(ts_valid), .upd(upd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int qavg(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s / DEPTH;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      repeat (DEPTH) begin
         q0.push_back(0);
         q1.push_back(0);
      end
      cnt0 = 0; cnt1 = 0;
      e1 = 0; e2 = 0; ev = 0; eu = 0;
   endtask

   // One clock: drive inputs, advance the model, then compare on the falling edge
   task automatic step(input string tag, input bit r, input bit v, input bit c, input int d);
      rst = r; s_valid = v; s_ch = c; s_data = W'(d);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         eu = v;
         if (v) begin
            if (!c) begin
               void'(q0.pop_front()); q0.push_back(d); cnt0++; e1 = qavg(q0);
            end else begin
               void'(q1.pop_front()); q1.push_back(d); cnt1++; e2 = qavg(q1);
            end
         end
         ev = (cnt0 >= DEPTH && cnt1 >= DEPTH);
      end
      @(negedge clk);
      chk({tag, ".ts1"}, 32'(ts1), 32'(e1));
      chk({tag, ".ts2"}, 32'(ts2), 32'(e2));
      chk({tag, ".ts_valid"}, 32'(ts_valid), 32'(ev));
      chk({tag, ".upd"}, 32'(upd), 32'(eu));
   endtask

   initial begin
      model_reset();
      step("reset", 1, 0, 0, 0);
      step("reset2", 1, 1, 1, 99);
      chk("reset_ts1_zero", 32'(ts1), 32'd0);

      // Ramp-up on channel 1 with constant 40
      for (int i = 0; i < DEPTH; i++) begin
         step("s1", 0, 1, 0, 40);
         chk("s1_step", 32'(ts1), 32'(5 * (i + 1)));
      end

      // Fill channel 2; ts_valid rises right after the last one
      for (int i = 0; i < DEPTH; i++) begin
         step("s2", 0, 1, 1, 100);
         chk("s2_tsv", 32'(ts_valid), (i == DEPTH - 1) ? 32'd1 : 32'd0);
         chk("s2_ts1_hold", 32'(ts1), 32'd40);
      end

      // Sliding window and pointer wrap
      step("s3a", 0, 1, 0, 120);
      chk("s3_first", 32'(ts1), 32'd50);
      for (int i = 0; i < DEPTH - 1; i++) step("s3b", 0, 1, 0, 120);
      chk("s3_full", 32'(ts1), 32'd120);
      step("s3c", 0, 1, 0, 120);
      chk("s3_wrap", 32'(ts1), 32'd120);

      // Truncation and full-scale
      for (int i = 0; i < DEPTH; i++) step("s4a", 0, 1, 0, i);
      chk("s4_trunc", 32'(ts1), 32'd3);
      for (int i = 0; i < DEPTH; i++) step("s4b", 0, 1, 0, 255);
      chk("s4_max", 32'(ts1), 32'd255);

      // Interleaving with idle gaps
      for (int i = 0; i < 6; i++) begin
         step("s5a", 0, 1, 0, 10);
         step("s5i", 0, 0, 0, 0);
         chk("s5_upd_idle", 32'(upd), 32'd0);
         step("s5b", 0, 1, 1, 200);
         step("s5i", 0, 0, 1, 0);
         step("s5i", 0, 0, 0, 0);
      end

      // Reset with a sample in the same cycle, then refill
      step("s6rst", 1, 1, 0, 77);
      chk("s6_ts1_zero", 32'(ts1), 32'd0);
      chk("s6_tsv_zero", 32'(ts_valid), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) step("s6a", 0, 1, 0, 60);
      for (int i = 0; i < DEPTH; i++) step("s6b", 0, 1, 1, 30);
      chk("s6_not_yet", 32'(ts_valid), 32'd0);
      step("s6c", 0, 1, 0, 60);
      chk("s6_refilled", 32'(ts_valid), 32'd1);

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         step("rnd", ($urandom_range(63) == 0), ($urandom_range(3) != 0),
              1'($urandom_range(1)), int'($urandom_range(255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
